store_rmw_unit: RTL and testbench

- Write-side counterpart of the load/store sub-word block (LScontrol), which extracts byte, half or word fields from memory data on loads.
- Sequences stores into Memoria.
  - SW: direct single-cycle write.
  - SH/SB: read-modify-write. Read the addressed word, merge the low byte or half of register B into it, write it back.
- Sits between regB/aluOut and the memory port, under control-unit start/done handshake.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/store_merge.sv | 22 ++
 rtl/store_rmw_unit.sv | 110 +++++++++++
 tb/tb_store_rmw_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared store-path definitions: size codes, sequencer states
// and the default Memoria read latency.
package cpu_pkg;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_INV  = 2'b11;

   localparam int MEM_LAT_DEF = 1;
   localparam int CNT_W       = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_MERGE,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   function automatic logic is_rmw(input logic [1:0] sz);
      return (sz == SZ_HALF) || (sz == SZ_BYTE);
   endfunction

endpackage

// File: rtl/store_merge.sv
// Merges the low byte/half of a store operand into an old word;
// the low lanes are replaced, mirroring the load-side extraction.
module store_merge
   import cpu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   output logic [31:0] merged
);

   always_comb begin
      merged = old_word;
      unique case (size)
         SZ_WORD: merged = wdata;
         SZ_HALF: merged = {old_word[31:16], wdata[15:0]};
         SZ_BYTE: merged = {old_word[31:8], wdata[7:0]};
         default: merged = old_word;
      endcase
   end

endmodule

// File: rtl/store_rmw_unit.sv
// Store sequencer for Memoria: direct word writes and
// read-modify-write for half/byte stores.
module store_rmw_unit
   import cpu_pkg::*;
#(
   parameter int MEM_LAT = MEM_LAT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [31:0] mem_dout,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   output logic        mem_wr,
   output logic        busy,
   output logic        done,
   output logic        err
);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [31:0]        addr_q;
   logic [31:0]        wdata_q;
   logic [1:0]         size_q;
   logic [31:0]        merged;

   store_merge u_merge (
      .size     (size_q),
      .old_word (mem_dout),
      .wdata    (wdata_q),
      .merged   (merged)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         size_q   <= '0;
         mem_addr <= '0;
         mem_din  <= '0;
         mem_wr   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         mem_wr <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  addr_q   <= addr;
                  wdata_q  <= wdata;
                  size_q   <= size;
                  mem_addr <= addr;
                  busy     <= 1'b1;
                  if (size == SZ_WORD) begin
                     mem_din <= wdata;
                     mem_wr  <= 1'b1;
                     state   <= S_WRITE;
                  end else if (is_rmw(size)) begin
                     cnt   <= CNT_W'(MEM_LAT - 1);
                     state <= S_READ;
                  end else begin
                     err   <= 1'b1;
                     state <= S_ERR;
                  end
               end
            end
            S_READ: begin
               mem_addr <= addr_q;
               if (cnt == '0) begin
                  state <= S_MERGE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            // mem_dout is valid in this state; merge and arm the write
            S_MERGE: begin
               mem_din <= merged;
               mem_wr  <= 1'b1;
               state   <= S_WRITE;
            end
            S_WRITE: begin
               mem_addr <= addr_q;
               done     <= 1'b1;
               state    <= S_DONE;
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            S_ERR: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed bench for store_rmw_unit with MEM_LAT=1 and MEM_LAT=3
// instances, each fed by a small latency-accurate memory model.
module tb_store_rmw_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start1, start3;
   logic [1:0]  size1, size3;
   logic [31:0] addr1, addr3, wdata1, wdata3;
   logic [31:0] dout1, dout3, ma1, ma3, md1, md3;
   logic        mw1, mw3, busy1, busy3, done1, done3, err1, err3;
   logic [31:0] img1, img3, img_addr1, img_addr3;
   logic [31:0] p3a, p3b;
   logic        sel3;

   int errors = 0;
   int checks = 0;

   always @(posedge clk)
      dout1 <= (ma1 == img_addr1) ? img1 : 32'hBAD0_BAD0;

   always @(posedge clk) begin
      p3a   <= (ma3 == img_addr3) ? img3 : 32'hBAD0_BAD0;
      p3b   <= p3a;
      dout3 <= p3b;
   end

   store_rmw_unit #(.MEM_LAT(1)) u1 (
      .clk(clk), .reset(rst_n), .start(start1), .size(size1),
      .addr(addr1), .wdata(wdata1), .mem_dout(dout1),
      .mem_addr(ma1), .mem_din(md1), .mem_wr(mw1),
      .busy(busy1), .done(done1), .err(err1)
   );

   store_rmw_unit #(.MEM_LAT(3)) u3 (
      .clk(clk), .reset(rst_n), .start(start3), .size(size3),
      .addr(addr3), .wdata(wdata3), .mem_dout(dout3),
      .mem_addr(ma3), .mem_din(md3), .mem_wr(mw3),
      .busy(busy3), .done(done3), .err(err3)
   );

   wire        o_wr   = sel3 ? mw3 : mw1;
   wire        o_done = sel3 ? done3 : done1;
   wire        o_err  = sel3 ? err3 : err1;
   wire        o_busy = sel3 ? busy3 : busy1;
   wire [31:0] o_addr = sel3 ? ma3 : ma1;
   wire [31:0] o_din  = sel3 ? md3 : md1;

   int          wr_cyc[$];
   logic [31:0] wr_din[$];
   logic [31:0] wr_addr[$];
   int          done_cyc[$];
   int          err_cyc[$];
   int          busy_cnt;

   task automatic launch(input bit s3, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] w,
                         input bit hold);
      @(negedge clk);
      sel3 = s3;
      if (s3) begin
         start3 = 1'b1; size3 = sz; addr3 = a; wdata3 = w;
      end else begin
         start1 = 1'b1; size1 = sz; addr1 = a; wdata1 = w;
      end
      @(posedge clk);
      #1;
      if (!hold) begin
         start1 = 1'b0; start3 = 1'b0;
         size1 = 2'b11; size3 = 2'b11;
         addr1 = 32'hFFFF_FFF0; addr3 = 32'hFFFF_FFF0;
         wdata1 = 32'h0; wdata3 = 32'h0;
      end
   endtask

   task automatic observe(input int n, input int chg, input int drop);
      wr_cyc.delete(); wr_din.delete(); wr_addr.delete();
      done_cyc.delete(); err_cyc.delete();
      busy_cnt = 0;
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         if (o_wr) begin
            wr_cyc.push_back(c);
            wr_din.push_back(o_din);
            wr_addr.push_back(o_addr);
         end
         if (o_done) done_cyc.push_back(c);
         if (o_err) err_cyc.push_back(c);
         if (o_busy) busy_cnt++;
         if (c == chg) wdata1 = 32'h0000_0077;
         if (c == drop) start1 = 1'b0;
      end
   endtask

   task automatic check_rmw(input string nm, input logic [31:0] exp_din,
                            input logic [31:0] exp_addr,
                            input int exp_wr, input int exp_done);
      int wc, dc;
      logic [31:0] wd, wa;
      wc = (wr_cyc.size() > 0) ? wr_cyc[0] : -1;
      wd = (wr_din.size() > 0) ? wr_din[0] : 32'hX;
      wa = (wr_addr.size() > 0) ? wr_addr[0] : 32'hX;
      dc = (done_cyc.size() > 0) ? done_cyc[0] : -1;
      checks++;
      if (wr_cyc.size() !== 1) begin
         errors++;
         $display("FAIL %s wr_count got=%0d exp=1", nm, wr_cyc.size());
      end
      checks++;
      if (wc !== exp_wr) begin
         errors++;
         $display("FAIL %s wr_cycle got=%0d exp=%0d", nm, wc, exp_wr);
      end
      checks++;
      if (wd !== exp_din) begin
         errors++;
         $display("FAIL %s din got=%h exp=%h", nm, wd, exp_din);
      end
      checks++;
      if (wa !== exp_addr) begin
         errors++;
         $display("FAIL %s addr got=%h exp=%h", nm, wa, exp_addr);
      end
      checks++;
      if (dc !== exp_done || done_cyc.size() !== 1) begin
         errors++;
         $display("FAIL %s done_cycle got=%0d n=%0d exp=%0d",
                  nm, dc, done_cyc.size(), exp_done);
      end
      checks++;
      if (busy_cnt !== exp_done) begin
         errors++;
         $display("FAIL %s busy_cycles got=%0d exp=%0d",
                  nm, busy_cnt, exp_done);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start1 = 0; start3 = 0; size1 = 0; size3 = 0;
      addr1 = 0; addr3 = 0; wdata1 = 0; wdata3 = 0;
      img1 = 0; img3 = 0; img_addr1 = 0; img_addr3 = 0;
      sel3 = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({mw1, busy1, done1, err1, mw3, busy3, done3, err3} !== 8'h00) begin
         errors++;
         $display("FAIL reset_flags got=%b exp=00000000",
                  {mw1, busy1, done1, err1, mw3, busy3, done3, err3});
      end
      checks++;
      if ({ma1, md1, ma3, md3} !== 128'h0) begin
         errors++;
         $display("FAIL reset_bus got=%h %h %h %h exp=0", ma1, md1, ma3, md3);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy1, busy3, mw1, mw3} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_release got=%b exp=0000",
                  {busy1, busy3, mw1, mw3});
      end
   endtask

   task automatic test_word();
      launch(0, 2'b00, 32'h40, 32'hDEAD_BEEF, 0);
      observe(5, 0, 0);
      check_rmw("word", 32'hDEAD_BEEF, 32'h40, 1, 2);
   endtask

   task automatic test_byte();
      img_addr1 = 32'h84; img1 = 32'h1122_3344;
      launch(0, 2'b10, 32'h84, 32'hAABB_CCDD, 0);
      observe(7, 0, 0);
      check_rmw("byte_lat1", 32'h1122_33DD, 32'h84, 3, 4);
   endtask

   task automatic test_half();
      img_addr3 = 32'h10; img3 = 32'h1122_3344;
      launch(1, 2'b01, 32'h10, 32'h0000_BEEF, 0);
      observe(9, 0, 0);
      check_rmw("half_lat3", 32'h1122_BEEF, 32'h10, 5, 6);
      img_addr1 = 32'h87; img1 = 32'hCAFE_F00D;
      launch(0, 2'b01, 32'h87, 32'h1234_5678, 0);
      observe(7, 0, 0);
      check_rmw("half_lat1_unaligned", 32'hCAFE_5678, 32'h87, 3, 4);
   endtask

   task automatic test_err();
      launch(0, 2'b11, 32'h20, 32'h5555_5555, 0);
      observe(5, 0, 0);
      checks++;
      if (err_cyc.size() !== 1 || err_cyc[0] !== 1) begin
         errors++;
         $display("FAIL err_pulse got=%0d pulses exp=1 at cycle 1",
                  err_cyc.size());
      end
      checks++;
      if (wr_cyc.size() !== 0 || done_cyc.size() !== 0) begin
         errors++;
         $display("FAIL err_side got wr=%0d done=%0d exp=0 0",
                  wr_cyc.size(), done_cyc.size());
      end
      checks++;
      if (busy_cnt !== 1) begin
         errors++;
         $display("FAIL err_busy got=%0d exp=1", busy_cnt);
      end
   endtask

   task automatic test_back_to_back();
      img_addr1 = 32'h84; img1 = 32'h1122_3344;
      launch(0, 2'b10, 32'h84, 32'hAABB_CCDD, 1);
      observe(13, 1, 9);
      checks++;
      if (wr_cyc.size() !== 2) begin
         errors++;
         $display("FAIL b2b_wr_count got=%0d exp=2", wr_cyc.size());
      end else begin
         checks++;
         if (wr_cyc[0] !== 3 || wr_cyc[1] !== 8) begin
            errors++;
            $display("FAIL b2b_wr_cycles got=%0d,%0d exp=3,8",
                     wr_cyc[0], wr_cyc[1]);
         end
         checks++;
         if (wr_din[0] !== 32'h1122_33DD || wr_din[1] !== 32'h1122_3377) begin
            errors++;
            $display("FAIL b2b_din got=%h,%h exp=112233dd,11223377",
                     wr_din[0], wr_din[1]);
         end
      end
      checks++;
      if (done_cyc.size() !== 2) begin
         errors++;
         $display("FAIL b2b_done_count got=%0d exp=2", done_cyc.size());
      end else begin
         checks++;
         if (done_cyc[0] !== 4 || done_cyc[1] !== 9) begin
            errors++;
            $display("FAIL b2b_done_cycles got=%0d,%0d exp=4,9",
                     done_cyc[0], done_cyc[1]);
         end
      end
   endtask

   task automatic test_reset_mid_read();
      img_addr3 = 32'h10; img3 = 32'h1122_3344;
      launch(1, 2'b10, 32'h10, 32'hAABB_CCDD, 0);
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({mw3, busy3, done3} !== 3'b000 || ma3 !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid got wr/busy/done=%b addr=%h exp=000 0",
                  {mw3, busy3, done3}, ma3);
      end
      @(negedge clk);
      rst_n = 1'b1;
      observe(8, 0, 0);
      checks++;
      if (wr_cyc.size() !== 0 || done_cyc.size() !== 0 || busy_cnt !== 0) begin
         errors++;
         $display("FAIL rst_after got wr=%0d done=%0d busy=%0d exp=0 0 0",
                  wr_cyc.size(), done_cyc.size(), busy_cnt);
      end
      launch(1, 2'b10, 32'h10, 32'h0000_00EE, 0);
      observe(9, 0, 0);
      check_rmw("rst_next_op", 32'h1122_33EE, 32'h10, 5, 6);
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_err();
      test_back_to_back();
      test_reset_mid_read();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
